// File: rtl/sync_barrier_master_pkg.sv
// Shared defaults and sizing helpers for the sync barrier responder and its core slots.
package sync_barrier_master_pkg;

    localparam int unsigned DEF_NUM_CORES          = 4;
    localparam int unsigned DEF_SYNC_BARRIER_WIDTH = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES     = 1024;

    // Width of the round-robin scan pointer for n cores (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sync_barrier_master_core_slot.sv
// Per-core arrival slot: pending flag, captured barrier id, wait counter and sticky errors.
module sync_barrier_master_core_slot
    import sync_barrier_master_pkg::*;
#(
    parameter int unsigned SYNC_BARRIER_WIDTH = DEF_SYNC_BARRIER_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_en,
    input  logic [SYNC_BARRIER_WIDTH-1:0] i_id,
    input  logic                          i_release,
    input  logic                          i_err_clear,
    output logic                          o_pending,
    output logic                          o_pending_nxt_c,
    output logic [SYNC_BARRIER_WIDTH-1:0] o_id,
    output logic                          o_double_err,
    output logic                          o_timeout_err
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

    logic                          r_pending;
    logic [SYNC_BARRIER_WIDTH-1:0] r_id;
    logic [CNT_W-1:0]              r_wait;
    logic                          r_double_err;
    logic                          r_timeout_err;

    logic w_double;
    logic w_accept;
    logic w_hold;
    logic w_timeout;
    logic w_pending_nxt;

    // Arrival classification: a strobe on a released edge is a fresh arrival, not a double.
    always_comb begin
        w_double      = i_en && r_pending && !i_release;
        w_accept      = i_en && !w_double;
        w_hold        = r_pending && !i_release && !w_accept;
        w_timeout     = w_hold && (r_wait == LIMIT_M1);
        w_pending_nxt = w_accept || w_hold;
    end

    // Slot state; wait counter restarts on a fresh arrival and saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending     <= 1'b0;
            r_id          <= '0;
            r_wait        <= '0;
            r_double_err  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_accept) begin
                r_id <= i_id;
            end
            if (!w_hold) begin
                r_wait <= '0;
            end else if (r_wait != LIMIT) begin
                r_wait <= r_wait + CNT_W'(1);
            end
            r_double_err  <= w_double  || (r_double_err  && !i_err_clear);
            r_timeout_err <= w_timeout || (r_timeout_err && !i_err_clear);
        end
    end

    assign o_pending       = r_pending;
    assign o_pending_nxt_c = w_pending_nxt;
    assign o_id            = r_id;
    assign o_double_err    = r_double_err;
    assign o_timeout_err   = r_timeout_err;

endmodule

// File: rtl/sync_barrier_master.sv
// Sync barrier responder: per-core slots, participant mask table, round-robin release scanner.
module sync_barrier_master
    import sync_barrier_master_pkg::*;
#(
    parameter int unsigned NUM_CORES          = DEF_NUM_CORES,
    parameter int unsigned SYNC_BARRIER_WIDTH = DEF_SYNC_BARRIER_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CORES*SYNC_BARRIER_WIDTH-1:0] sync_barrier_in,
    input  logic [NUM_CORES-1:0]                    sync_en_in,
    output logic [NUM_CORES-1:0]                    sync_enable,
    input  logic                                    cfg_we,
    input  logic [SYNC_BARRIER_WIDTH-1:0]           cfg_addr,
    input  logic [NUM_CORES-1:0]                    cfg_mask,
    input  logic                                    err_clear,
    output logic [NUM_CORES-1:0]                    double_arrival_err,
    output logic [NUM_CORES-1:0]                    mask_err,
    output logic [NUM_CORES-1:0]                    timeout_err,
    output logic                                    busy
);

    localparam int unsigned W     = SYNC_BARRIER_WIDTH;
    localparam int unsigned N     = NUM_CORES;
    localparam int unsigned PTR_W = ptr_width(N);
    localparam int unsigned DEPTH = 1 << W;

    logic [N-1:0]     r_mask [DEPTH];
    logic [PTR_W-1:0] r_scan_ptr;
    logic [N-1:0]     r_sync_enable;
    logic [N-1:0]     r_mask_err;
    logic             r_busy;

    logic [N-1:0]   w_pending;
    logic [N-1:0]   w_pending_nxt;
    logic [N*W-1:0] w_ids;
    logic [N-1:0]   w_double_err;
    logic [N-1:0]   w_timeout_err;

    logic [W-1:0] w_id_p;
    logic         w_pend_p;
    logic [N-1:0] w_onehot_p;
    logic [N-1:0] w_m;
    logic         w_all_in;
    logic         w_in_mask;
    logic [N-1:0] w_release;
    logic [N-1:0] w_mask_err_set;

    genvar g;
    for (g = 0; g < N; g++) begin : g_slot
        sync_barrier_master_core_slot #(
            .SYNC_BARRIER_WIDTH (W),
            .TIMEOUT_CYCLES     (TIMEOUT_CYCLES)
        ) u_slot (
            .clk             (clk),
            .reset           (reset),
            .i_en            (sync_en_in[g]),
            .i_id            (sync_barrier_in[g*W +: W]),
            .i_release       (w_release[g]),
            .i_err_clear     (err_clear),
            .o_pending       (w_pending[g]),
            .o_pending_nxt_c (w_pending_nxt[g]),
            .o_id            (w_ids[g*W +: W]),
            .o_double_err    (w_double_err[g]),
            .o_timeout_err   (w_timeout_err[g])
        );
    end

    // Evaluate the core under the scan pointer: full barrier release or lone mask-error release.
    always_comb begin
        w_id_p         = '0;
        w_pend_p       = 1'b0;
        w_onehot_p     = '0;
        for (int j = 0; j < N; j++) begin
            if (r_scan_ptr == PTR_W'(j)) begin
                w_id_p        = w_ids[j*W +: W];
                w_pend_p      = w_pending[j];
                w_onehot_p[j] = 1'b1;
            end
        end
        w_m      = r_mask[w_id_p];
        w_all_in = 1'b1;
        for (int j = 0; j < N; j++) begin
            if (w_m[j] && !(w_pending[j] && (w_ids[j*W +: W] == w_id_p))) begin
                w_all_in = 1'b0;
            end
        end
        w_in_mask      = |(w_m & w_onehot_p);
        w_release      = '0;
        w_mask_err_set = '0;
        if (w_pend_p && w_in_mask && w_all_in) begin
            w_release = w_m;
        end else if (w_pend_p && !w_in_mask) begin
            w_release      = w_onehot_p;
            w_mask_err_set = w_onehot_p;
        end
    end

    // Scanner, release pulse, mask-error sticky bits and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_ptr    <= '0;
            r_sync_enable <= '0;
            r_mask_err    <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_scan_ptr    <= (r_scan_ptr == PTR_W'(N - 1)) ? '0 : r_scan_ptr + PTR_W'(1);
            r_sync_enable <= w_release;
            r_mask_err    <= w_mask_err_set | (r_mask_err & {N{~err_clear}});
            r_busy        <= |w_pending_nxt;
        end
    end

    // Participant mask table; deliberately survives reset.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            r_mask[cfg_addr] <= cfg_mask;
        end
    end

    assign sync_enable        = r_sync_enable;
    assign double_arrival_err = w_double_err;
    assign mask_err           = r_mask_err;
    assign timeout_err        = w_timeout_err;
    assign busy               = r_busy;

endmodule
